// File: rtl/seg7_display_decoder.sv
// Monitors a multiplexed dual seven-segment bus and recovers the displayed tens/ones digits.
// Optional macro SEG7_DECODE_HEX_EN adds decoding of the A..F letter patterns.
module seg7_display_decoder #(
  parameter int unsigned STABLE_CNT = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] disp_in,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       tens_blank,
  output logic       ones_blank,
  output logic [6:0] value,
  output logic       value_ok,
  output logic       value_valid,
  output logic       frame_pulse,
  output logic       seg_err,
  output logic       stale
);

  localparam int unsigned CW = 4;
  localparam int unsigned TW = 16;

  typedef enum logic [1:0] {HUNT, TENS, ONES} state_t;

  logic [7:0]    disp_q, disp_p;
  logic [CW-1:0] stab_cnt;
  logic          acc_done;
  logic          acc_q, acc_blank, acc_bad;
  logic [3:0]    acc_digit;
  logic          rise_q, fall_q;
  state_t        state;
  logic [3:0]    sh_tens;
  logic          sh_blank, tens_got, bad;
  logic [TW-1:0] to_cnt;

  logic          sel_rise_c, sel_fall_c, sel_edge_c, accept_c;
  logic [CW-1:0] stab_next_c;
  logic [3:0]    dec_digit_c;
  logic          dec_blank_c, dec_bad_c;
  state_t        st_eff_c;
  logic          commit_ok_c, to_hit_c;
  logic [6:0]    value_c;

  // Select-phase edges and stability counting on the registered samples
  always_comb begin
    sel_rise_c  = disp_q[7] & ~disp_p[7];
    sel_fall_c  = ~disp_q[7] & disp_p[7];
    sel_edge_c  = sel_rise_c | sel_fall_c;
    stab_next_c = (disp_q != disp_p) ? CW'(1)
                : (stab_cnt == CW'(15)) ? CW'(15) : stab_cnt + CW'(1);
    // a select edge opens a new phase, so its own accept is never blocked
    accept_c    = (stab_next_c == CW'(STABLE_CNT)) && (!acc_done || sel_edge_c);
  end

  // Exact-match segment decode of the current sample
  always_comb begin
    dec_digit_c = 4'd0;
    dec_blank_c = 1'b0;
    dec_bad_c   = 1'b0;
    case (disp_q[6:0])
      7'b0111111: dec_digit_c = 4'd0;
      7'b0000110: dec_digit_c = 4'd1;
      7'b1011011: dec_digit_c = 4'd2;
      7'b1001111: dec_digit_c = 4'd3;
      7'b1100110: dec_digit_c = 4'd4;
      7'b1101101: dec_digit_c = 4'd5;
      7'b1111101: dec_digit_c = 4'd6;
      7'b0000111: dec_digit_c = 4'd7;
      7'b1111111: dec_digit_c = 4'd8;
      7'b1101111: dec_digit_c = 4'd9;
      7'b0000000: dec_blank_c = 1'b1;
`ifdef SEG7_DECODE_HEX_EN
      7'b1110111: dec_digit_c = 4'hA;
      7'b1111100: dec_digit_c = 4'hB;
      7'b0111001: dec_digit_c = 4'hC;
      7'b1011110: dec_digit_c = 4'hD;
      7'b1111001: dec_digit_c = 4'hE;
      7'b1110001: dec_digit_c = 4'hF;
`endif
      default:    dec_bad_c   = 1'b1;
    endcase
  end

  // Phase the FSM is entering; a coincident accept is applied in that phase
  always_comb begin
    st_eff_c = state;
    if (rise_q) begin
      st_eff_c = TENS;
    end else if (fall_q) begin
      st_eff_c = (state == TENS && tens_got) ? ONES : HUNT;
    end
    commit_ok_c = !sh_blank && !acc_blank && (sh_tens <= 4'd9) && (acc_digit <= 4'd9);
    value_c     = 7'(sh_tens) * 7'd10 + 7'(acc_digit);
    to_hit_c    = !(rise_q | fall_q) && (to_cnt == TW'(TIMEOUT - 1));
  end

  // Input sampling, stability counter and accept/edge staging
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q    <= '0;
      disp_p    <= '0;
      stab_cnt  <= '0;
      acc_done  <= 1'b0;
      acc_q     <= 1'b0;
      acc_digit <= '0;
      acc_blank <= 1'b0;
      acc_bad   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      disp_q    <= disp_in;
      disp_p    <= disp_q;
      stab_cnt  <= stab_next_c;
      acc_done  <= sel_edge_c ? accept_c : (acc_done | accept_c);
      acc_q     <= accept_c;
      acc_digit <= dec_digit_c;
      acc_blank <= dec_blank_c;
      acc_bad   <= dec_bad_c;
      rise_q    <= sel_rise_c;
      fall_q    <= sel_fall_c;
    end
  end

  // Frame FSM, shadow tens, committed outputs and timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      sh_tens     <= '0;
      sh_blank    <= 1'b0;
      tens_got    <= 1'b0;
      bad         <= 1'b0;
      to_cnt      <= '0;
      tens        <= '0;
      ones        <= '0;
      tens_blank  <= 1'b0;
      ones_blank  <= 1'b0;
      value       <= '0;
      value_ok    <= 1'b0;
      value_valid <= 1'b0;
      frame_pulse <= 1'b0;
      seg_err     <= 1'b0;
      stale       <= 1'b0;
    end else begin
      frame_pulse <= 1'b0;
      seg_err     <= 1'b0;
      stale       <= 1'b0;
      if (rise_q | fall_q) begin
        to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT)) begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (to_hit_c) begin
        stale       <= 1'b1;
        value_valid <= 1'b0;
        state       <= HUNT;
        tens_got    <= 1'b0;
        bad         <= 1'b0;
      end else begin
        state <= st_eff_c;
        if (rise_q) begin
          tens_got <= 1'b0;
          bad      <= 1'b0;
        end
        if (acc_q) begin
          case (st_eff_c)
            TENS: begin
              sh_tens  <= acc_digit;
              sh_blank <= acc_blank;
              tens_got <= 1'b1;
              bad      <= acc_bad;
              seg_err  <= acc_bad;
            end
            ONES: begin
              seg_err  <= acc_bad;
              tens_got <= 1'b0;
              bad      <= 1'b0;
              if (tens_got && !bad && !acc_bad) begin
                tens        <= sh_tens;
                ones        <= acc_digit;
                tens_blank  <= sh_blank;
                ones_blank  <= acc_blank;
                value_ok    <= commit_ok_c;
                value       <= commit_ok_c ? value_c : 7'd0;
                value_valid <= 1'b1;
                frame_pulse <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
